// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_prog_if.sv
// Control/status bundle for the programmable clock divider.
`timescale 1ns/10ps
interface gf180mcu_osu_sc_gp9t3v3__clkdiv_prog_if #(
  parameter int unsigned DIV_W = 4
);
  logic             EN;
  logic [DIV_W-1:0] DIV;
  logic             Y;
  logic             YN;
  logic             TICK;
  logic             RUN;

  // Requester side: drives run request and ratio, observes the divided clock.
  modport master (
    output EN, DIV,
    input  Y, YN, TICK, RUN
  );

  // Divider side.
  modport slave (
    input  EN, DIV,
    output Y, YN, TICK, RUN
  );
endinterface

// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.sv
// Glitch-free programmable clock divider, ratio R = DIV + 2.
// Ratio and start/stop are only taken at period boundaries; all outputs are flops.
`timescale 1ns/10ps
`celldefine
module gf180mcu_osu_sc_gp9t3v3__clkdiv_prog #(
  parameter int unsigned DIV_W = 4
) (
  input  logic CLK,
  input  logic RN,
  gf180mcu_osu_sc_gp9t3v3__clkdiv_prog_if.slave bus
);

  localparam int unsigned R_W   = DIV_W + 1;  // holds up to 2^DIV_W + 1
  localparam int unsigned CNT_W = DIV_W;      // holds up to 2^(DIV_W-1) + 1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [R_W-1:0]   r_ratio;
  logic [R_W-1:0]   w_ratio_nxt;
  logic             r_y;
  logic             w_y_nxt;
  logic             r_yn;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             r_run;

  logic [R_W-1:0]   w_r_new;
  logic [CNT_W-1:0] w_h_load_new;
  logic [CNT_W-1:0] w_l_load_cur;

  // Ratio for a period starting now, and its phase reload values.
  // High load = ceil(R/2)-1 = (R-1)>>1; low load = floor(R/2)-1.
  always_comb begin
    w_r_new      = R_W'(bus.DIV) + R_W'(2);
    w_h_load_new = CNT_W'((w_r_new - R_W'(1)) >> 1);
    w_l_load_cur = CNT_W'((r_ratio >> 1) - R_W'(1));
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ratio <= '0;
      r_y     <= 1'b0;
      r_yn    <= 1'b1;
      r_tick  <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      r_y     <= w_y_nxt;
      r_yn    <= ~w_y_nxt;
      r_tick  <= w_tick_nxt;
      r_run   <= (w_state_nxt != IDLE);
    end
  end

  // Next-state, phase counter and next output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ratio_nxt = r_ratio;
    w_y_nxt     = r_y;
    w_tick_nxt  = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_y_nxt = 1'b0;
        if (bus.EN) begin
          w_state_nxt = HIGH;
          w_ratio_nxt = w_r_new;
          w_cnt_nxt   = w_h_load_new;
          w_y_nxt     = 1'b1;
          w_tick_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = LOW;
          w_cnt_nxt   = w_l_load_cur;
          w_y_nxt     = 1'b0;
        end
      end
      LOW: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (bus.EN) begin
          // Back-to-back period: DIV is sampled only here.
          w_state_nxt = HIGH;
          w_ratio_nxt = w_r_new;
          w_cnt_nxt   = w_h_load_new;
          w_y_nxt     = 1'b1;
          w_tick_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_y_nxt     = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_y_nxt     = 1'b0;
      end
    endcase
  end

  assign bus.Y    = r_y;
  assign bus.YN   = r_yn;
  assign bus.TICK = r_tick;
  assign bus.RUN  = r_run;

endmodule
`endcelldefine

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.sv
// Directed bench for the programmable clock divider.
`timescale 1ns/10ps
module tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_prog;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  gf180mcu_osu_sc_gp9t3v3__clkdiv_prog_if #(.DIV_W(4)) bus ();

  gf180mcu_osu_sc_gp9t3v3__clkdiv_prog #(.DIV_W(4)) dut (
    .CLK (CLK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Compare {Y,YN,TICK,RUN} against expectation; YN must be ~Y.
  task automatic chk(input string tag, input int idx, input logic y, input logic tick, input logic run);
    logic [3:0] obs;
    logic [3:0] exp_v;
    obs   = {bus.Y, bus.YN, bus.TICK, bus.RUN};
    exp_v = {y, ~y, tick, run};
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s[%0d] {Y,YN,TICK,RUN} got %b want %b", tag, idx, obs, exp_v);
    end
  endtask

  // Advance one CLK edge and sample 1ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One full period of h high and l low cycles starting at the next edge.
  // Optionally changes DIV / drops EN / raises EN right after sample index *_at.
  task automatic period(input string tag, input int h, input int l,
                        input int div_at, input logic [3:0] div_v,
                        input int en0_at, input int en1_at);
    for (int i = 0; i < h + l; i++) begin
      step();
      if (i < h) chk(tag, i, 1'b1, (i == 0), 1'b1);
      else       chk(tag, i, 1'b0, 1'b0, 1'b1);
      if (i == div_at) bus.DIV = div_v;
      if (i == en0_at) bus.EN  = 1'b0;
      if (i == en1_at) bus.EN  = 1'b1;
    end
  endtask

  initial begin
    // 1. Reset and start at R=2
    bus.EN  = 1'b1;
    bus.DIV = 4'd0;
    #23;
    chk("reset", 0, 1'b0, 1'b0, 1'b0);
    step();
    chk("reset_hold", 0, 1'b0, 1'b0, 1'b0);
    RN = 1'b1;
    for (int p = 0; p < 3; p++) period("r2", 1, 1, -1, 4'd0, -1, -1);

    // 2. Odd ratios R=3 and R=17
    bus.DIV = 4'd1;
    period("r3a", 2, 1, -1, 4'd0, -1, -1);
    period("r3b", 2, 1, -1, 4'd0, -1, -1);
    bus.DIV = 4'd15;
    period("r17", 9, 8, -1, 4'd0, -1, -1);

    // 3. Ratio change mid-high: current period keeps R=4, next is R=8
    bus.DIV = 4'd2;
    period("r4_chg", 2, 2, 0, 4'd6, -1, -1);
    period("r8", 4, 4, -1, 4'd0, -1, -1);

    // 4. Stop handling at R=5
    bus.DIV = 4'd3;
    period("r5_blip", 3, 2, -1, 4'd0, 0, 1);
    period("r5_stop", 3, 2, -1, 4'd0, 0, -1);
    step();
    chk("idle_term", 0, 1'b0, 1'b0, 1'b0);

    // 6. Restart from IDLE one cycle after stop
    bus.EN = 1'b1;
    period("restart", 3, 2, -1, 4'd0, -1, -1);

    // 5. Async reset mid-HIGH at R=9
    bus.DIV = 4'd7;
    step();
    chk("r9_h", 0, 1'b1, 1'b1, 1'b1);
    step();
    chk("r9_h", 1, 1'b1, 1'b0, 1'b1);
    #2;
    RN = 1'b0;
    #1;
    chk("async_rst", 0, 1'b0, 1'b0, 1'b0);
    bus.EN = 1'b0;
    #10;
    RN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_after_rst", i, 1'b0, 1'b0, 1'b0);
    end

    // Restart after reset: ratio taken fresh from DIV (R=9)
    bus.EN = 1'b1;
    period("r9_full", 5, 4, -1, 4'd0, 3, -1);
    step();
    chk("final_idle", 0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.md
Name: gf180mcu_osu_sc_gp9t3v3__clkdiv_prog

Overview:
Programmable glitch-free clock divider and generator for the 9T 3.3V library. It is the source end of a clock tree: it drives the root of the tree, which the clkinv/clkbuf cells then distribute. The block produces a divided clock Y, its complement YN, a per-period TICK strobe and a RUN status. Ratio changes and start/stop occur only at period boundaries, so Y never glitches or produces a runt pulse.

Parameters:
DIV_W, 4, width of the DIV ratio code. Division ratio R = DIV + 2, giving a range of 2 to 2^DIV_W+1 (2..17 at the default).

Ports:
CLK  input  1  source clock. All state updates on its rising edge.
RN  input  1  asynchronous active-low reset.
EN  input  1  run request; sampled on CLK rise.
DIV  input  DIV_W  ratio code; R = DIV + 2. Sampled only at a period start.
Y  output  1  divided clock, registered.
YN  output  1  complement of Y, from its own register. Never equal to Y outside reset.
TICK  output  1  one-CLK-cycle pulse, high in the first cycle of each Y high phase.
RUN  output  1  high while a period is in progress, i.e. state != IDLE.

Behaviour:
- One clock (CLK), rising-edge only; reset RN is asynchronous, active-low. Async assert at any time gives immediately: Y=0, YN=1, TICK=0, RUN=0, state=IDLE, counter=0, latched ratio=0. Deassertion is synchronous in effect: the first active edge is the first CLK rise after RN goes high.
- Every output is a flop output; no combinational path from CLK, EN or DIV to Y/YN.
- Phase lengths for latched ratio R:
  - high phase H = ceil(R/2) cycles.
  - low phase L = floor(R/2) cycles.
  - Examples: R=2 gives 1/1, R=3 gives 2/1, R=17 gives 9/8.
- States: IDLE, HIGH, LOW. The down-counter is wide enough for 2^(DIV_W-1)+1.
- IDLE:
  - EN=0 at an edge: stay; Y=0.
  - EN=1 at edge k: latch R=DIV+2, go to HIGH, load counter=H-1. From edge k onward Y=1, YN=0, TICK=1, RUN=1. Latency is 1 edge.
- HIGH:
  - Each edge with counter>0: decrement, TICK=0.
  - Edge with counter==0: go to LOW, load counter=L-1, Y=0, YN=1.
- LOW:
  - Each edge with counter>0: decrement.
  - Edge with counter==0 and EN=1: latch a new R from the current DIV, go to HIGH, Y=1, TICK=1. Periods run back-to-back with no gap.
  - Edge with counter==0 and EN=0: go to IDLE, RUN=0, Y stays 0.
- EN drop mid-period never truncates the period; the current high and low phases always complete. EN pulses while RUN=1 and the state is not at the LOW terminal edge are ignored.
- DIV changes mid-period are ignored until the next period-start edge. DIV is sampled exactly at that edge.
- TICK is high exactly one cycle per period, coincident with the first Y-high cycle.
- Reset mid-period: the output goes to Y=0 immediately. The runt is accepted as reset behaviour only.
- Timing arcs are zero-delay for (CLK => Y, YN, TICK, RUN) and (RN => Y, YN, TICK, RUN).
- `timescale 1ns/10ps; celldefine'd.

Test Plan:
1. Reset and start: RN=0 with EN=1 and DIV=0 gives Y=0, YN=1, RUN=0. Release RN: first rise gives Y=1, TICK=1. Y then toggles every cycle (period 2); TICK is high every 2nd cycle.
2. Odd ratio: DIV=1 (R=3) gives Y high 2 and low 1 cycles. DIV=15 (R=17) gives high 9 and low 8. Check YN==~Y on every cycle.
3. Ratio change mid-period: run DIV=2 (R=4), change to DIV=6 (R=8) mid-high. The current period stays 2/2; the next period is 4/4 and starts with TICK.
4. Stop: drop EN for 1 cycle during the HIGH phase of R=5. The period still completes (3 high, 2 low) and the next period starts because EN=1 at the boundary. Drop EN through the boundary: go to IDLE, RUN=0 on the terminal edge, Y stays 0, no further TICK.
5. Async reset mid-HIGH with R=9: Y=0, YN=1, RUN=0 without waiting for CLK. Release with EN=0 and check the block stays IDLE.
6. Restart from IDLE: raise EN one cycle after stop. Y rises on the first edge, with no back-to-back low-phase shortening.
